// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation codes, FSM encoding and the divide-by-zero quotient value.
package muldiv_pkg;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } state_e;

  // Which half (or both) of HI/LO the write-back cycle updates.
  typedef enum logic [1:0] {
    WB_BOTH = 2'd0,
    WB_HI   = 2'd1,
    WB_LO   = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the iterative mul/div unit: issues operations,
// commits results to HI/LO, stalls EX while HI/LO is pending.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MAX_LAT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        op_ready,
  output logic        stall,
  output logic        busy,
  output logic        unit_start,
  output logic        unit_div,
  output logic        unit_signed,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        unit_abort,
  input  logic        unit_done,
  input  logic [63:0] unit_result,
  input  logic [31:0] hi_rdata,
  input  logic [31:0] lo_rdata,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        mf_valid,
  output logic [31:0] mf_data,
  output logic        err_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);

  state_e            state_q, state_d;
  wb_sel_e           sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              div_q, div_d;
  logic              signed_q, signed_d;
  logic [63:0]       res_q, res_d;
  logic              err_q, err_d;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    div_d      = div_q;
    signed_d   = signed_q;
    res_d      = res_q;
    err_d      = err_q;
    op_ready   = 1'b0;
    mf_valid   = 1'b0;
    mf_data    = '0;
    unit_start = 1'b0;
    unit_abort = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          op_ready = 1'b1;
          case (op_code)
            OP_MFHI: begin
              mf_valid = 1'b1;
              mf_data  = hi_rdata;
            end
            OP_MFLO: begin
              mf_valid = 1'b1;
              mf_data  = lo_rdata;
            end
            OP_MTHI, OP_MTLO: begin
              res_d   = {op_a, op_a};
              sel_d   = (op_code == OP_MTHI) ? WB_HI : WB_LO;
              state_d = WB;
            end
            default: begin
              // op_code[1] selects divide, op_code[0] selects signed.
              a_d      = op_a;
              b_d      = op_b;
              div_d    = op_code[1];
              signed_d = op_code[0];
              sel_d    = WB_BOTH;
              if (op_code[1] && (op_b == '0)) begin
                res_d   = {op_a, DIV0_LO};
                state_d = WB;
              end else begin
                state_d = ISSUE;
              end
            end
          endcase
        end
      end

      ISSUE: begin
        if (flush) begin
          unit_abort = 1'b1;
          state_d    = IDLE;
        end else begin
          unit_start = 1'b1;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          unit_abort = 1'b1;
          state_d    = IDLE;
        end else if (unit_done) begin
          res_d   = unit_result;
          state_d = WB;
        end else if (cnt_q == CNT_LAST) begin
          unit_abort = 1'b1;
          err_d      = 1'b1;
          state_d    = IDLE;
        end
      end

      WB: begin
        state_d = IDLE;
        if (!flush) begin
          hi_we = (sel_q != WB_LO);
          lo_we = (sel_q != WB_HI);
        end
      end

      default: state_d = IDLE;
    endcase

    // A reset arriving mid-operation must not leak a strobe or abort pulse.
    if (reset) begin
      op_ready   = 1'b0;
      mf_valid   = 1'b0;
      mf_data    = '0;
      unit_start = 1'b0;
      unit_abort = 1'b0;
      hi_we      = 1'b0;
      lo_we      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= WB_BOTH;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      signed_q <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      div_q    <= div_d;
      signed_q <= signed_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign stall       = op_valid & ~op_ready;
  assign busy        = (state_q != IDLE);
  assign unit_a      = a_q;
  assign unit_b      = b_q;
  assign unit_div    = div_q;
  assign unit_signed = signed_q;
  assign hi_wdata    = res_q[63:32];
  assign lo_wdata    = res_q[31:0];
  assign err_timeout = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: HI/LO storage model, scripted unit
// responses and a scoreboard of expected HI/LO writes.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, flush, unit_done;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic [63:0] unit_result;
  logic        op_ready, stall, busy, unit_start, unit_div, unit_signed, unit_abort;
  logic [31:0] unit_a, unit_b, hi_rdata, lo_rdata, hi_wdata, lo_wdata, mf_data;
  logic        hi_we, lo_we, mf_valid, err_timeout;

  logic [31:0] hi_model = '0;
  logic [31:0] lo_model = '0;
  assign hi_rdata = hi_model;
  assign lo_rdata = lo_model;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MAX_LAT(40), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .flush(flush), .op_ready(op_ready),
    .stall(stall), .busy(busy), .unit_start(unit_start), .unit_div(unit_div),
    .unit_signed(unit_signed), .unit_a(unit_a), .unit_b(unit_b),
    .unit_abort(unit_abort), .unit_done(unit_done), .unit_result(unit_result),
    .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .mf_valid(mf_valid),
    .mf_data(mf_data), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi;
    logic [31:0] lo;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  starts   = 0;
  int  aborts   = 0;

  logic         s_ready, s_stall, s_busy, s_start, s_abort, s_div, s_signed;
  logic         s_hiwe, s_lowe, s_mfv, s_err;
  logic [31:0]  s_a, s_b, s_mfd, s_hiw, s_low;
  logic [170:0] s_all;

  function automatic wr_t mk(logic w_hi, logic w_lo, logic [31:0] hi, logic [31:0] lo);
    wr_t w;
    w.hi_we = w_hi;
    w.lo_we = w_lo;
    w.hi    = hi;
    w.lo    = lo;
    return w;
  endfunction

  // One clock: sample at negedge, score writes, update HI/LO model at posedge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    s_ready = op_ready;   s_stall = stall;     s_busy = busy;
    s_start = unit_start; s_abort = unit_abort;
    s_div = unit_div;     s_signed = unit_signed;
    s_a = unit_a;         s_b = unit_b;
    s_hiwe = hi_we;       s_lowe = lo_we;      s_hiw = hi_wdata;  s_low = lo_wdata;
    s_mfv = mf_valid;     s_mfd = mf_data;     s_err = err_timeout;
    s_all = {op_ready, stall, busy, unit_start, unit_div, unit_signed, unit_a,
             unit_b, unit_abort, hi_we, lo_we, hi_wdata, lo_wdata, mf_valid,
             mf_data, err_timeout};
    if (unit_start) starts++;
    if (unit_abort) aborts++;
    if (hi_we || lo_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got hi_we=%0b lo_we=%0b hi=%h lo=%h, required no write",
                 hi_we, lo_we, hi_wdata, lo_wdata);
      end else begin
        e = exp_q.pop_front();
        if (hi_we !== e.hi_we || lo_we !== e.lo_we ||
            (e.hi_we && hi_wdata !== e.hi) || (e.lo_we && lo_wdata !== e.lo)) begin
          n_fail++;
          $display("FAIL hilo_write: got we=%b%b hi=%h lo=%h, required we=%b%b hi=%h lo=%h",
                   hi_we, lo_we, hi_wdata, lo_wdata, e.hi_we, e.lo_we, e.hi, e.lo);
        end
      end
    end
    @(posedge clk);
    if (s_hiwe) hi_model = s_hiw;
    if (s_lowe) lo_model = s_low;
    #1;
  endtask

  task automatic drive(logic v, logic [2:0] code, logic [31:0] a, logic [31:0] b);
    op_valid = v;
    op_code  = code;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 3'd0, '0, '0);
    tick();
    tick();
    n_checks++;
    if (s_all !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", s_all); end
    reset = 1'b0;
    tick();
    n_checks++;
    if (s_busy !== 1'b0 || s_err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%0b err=%0b, required 0 0", s_busy, s_err);
    end
  endtask

  task automatic test_multu();
    int bad = 0;
    starts = 0;
    drive(1'b1, OP_MULTU, 32'd7, 32'd6);
    exp_q.push_back(mk(1'b1, 1'b1, 32'd0, 32'd42));
    tick();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL multu_accept: got %0b, required 1", s_ready); end
    drive(1'b1, OP_MFLO, '0, '0);
    for (int i = 1; i <= 35; i++) begin
      unit_done   = (i == 33);
      unit_result = (i == 33) ? 64'd42 : 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      if (i == 1) begin
        n_checks++;
        if ({s_start, s_div, s_signed, s_a, s_b} !== {3'b100, 32'd7, 32'd6}) begin
          n_fail++; $display("FAIL multu_issue: got start/div/sgn=%b%b%b a=%h b=%h, required 100 a=7 b=6",
                             s_start, s_div, s_signed, s_a, s_b);
        end
      end
      if (i <= 34 && (s_ready !== 1'b0 || s_stall !== 1'b1)) bad++;
      if (i == 34) begin
        n_checks++;
        if ({s_hiwe, s_lowe} !== 2'b11) begin
          n_fail++; $display("FAIL multu_wb_timing: got we=%b%b, required 11", s_hiwe, s_lowe);
        end
      end
      if (i == 35) begin
        n_checks++;
        if ({s_ready, s_mfv, s_mfd} !== {2'b11, 32'd42}) begin
          n_fail++; $display("FAIL multu_mflo: got ready=%0b mfv=%0b data=%h, required 1 1 2a",
                             s_ready, s_mfv, s_mfd);
        end
      end
    end
    unit_done = 1'b0;
    drive(1'b0, 3'd0, '0, '0);
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL multu_stall_span: got %0d bad cycles, required 0", bad); end
    n_checks++;
    if (starts !== 1 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL multu_counts: got starts=%0d pending=%0d, required 1 0", starts, exp_q.size());
    end
  endtask

  task automatic test_div_signed();
    drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back(mk(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
    tick();
    drive(1'b0, 3'd0, '0, '0);
    for (int i = 1; i <= 7; i++) begin
      unit_done   = (i == 5);
      unit_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tick();
      if (i == 1 || i == 5) begin
        n_checks++;
        if ({s_div, s_signed, s_a, s_b} !== {2'b11, 32'hFFFF_FFF9, 32'd2} || s_start !== (i == 1)) begin
          n_fail++; $display("FAIL div_ctrl_c%0d: got start=%0b div=%0b sgn=%0b a=%h b=%h, required div=1 sgn=1 a=fffffff9 b=2",
                             i, s_start, s_div, s_signed, s_a, s_b);
        end
      end
    end
    unit_done = 1'b0;
    drive(1'b1, OP_MFHI, '0, '0);
    tick();
    n_checks++;
    if ({s_mfv, s_mfd} !== {1'b1, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL div_mfhi: got mfv=%0b data=%h, required 1 ffffffff", s_mfv, s_mfd);
    end
    drive(1'b0, 3'd0, '0, '0);
  endtask

  task automatic test_div0();
    starts = 0;
    drive(1'b1, OP_DIVU, 32'd5, 32'd0);
    exp_q.push_back(mk(1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF));
    tick();
    n_checks++;
    if (s_ready !== 1'b1) begin n_fail++; $display("FAIL div0_accept: got %0b, required 1", s_ready); end
    drive(1'b1, OP_MFLO, '0, '0);
    tick();
    n_checks++;
    if ({s_busy, s_ready, s_hiwe, s_lowe} !== 4'b1011) begin
      n_fail++; $display("FAIL div0_wb: got busy/ready/we=%b%b%b%b, required 1011", s_busy, s_ready, s_hiwe, s_lowe);
    end
    tick();
    n_checks++;
    if ({s_busy, s_ready, s_mfv, s_mfd} !== {3'b011, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL div0_next: got busy=%0b ready=%0b mfv=%0b data=%h, required 0 1 1 ffffffff",
                         s_busy, s_ready, s_mfv, s_mfd);
    end
    drive(1'b0, 3'd0, '0, '0);
    tick();
    n_checks++;
    if (starts !== 0) begin n_fail++; $display("FAIL div0_no_start: got %0d starts, required 0", starts); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, OP_MTHI, 32'h1234, '0);
    exp_q.push_back(mk(1'b1, 1'b0, 32'h1234, '0));
    tick();
    drive(1'b1, OP_MFHI, '0, '0);
    tick();
    n_checks++;
    if ({s_ready, s_stall, s_hiwe, s_lowe} !== 4'b0110) begin
      n_fail++; $display("FAIL mthi_wb: got ready/stall/we=%b%b%b%b, required 0110", s_ready, s_stall, s_hiwe, s_lowe);
    end
    tick();
    n_checks++;
    if ({s_ready, s_mfv, s_mfd} !== {2'b11, 32'h1234}) begin
      n_fail++; $display("FAIL mfhi_after_mthi: got ready=%0b mfv=%0b data=%h, required 1 1 1234", s_ready, s_mfv, s_mfd);
    end
    drive(1'b1, OP_MTLO, 32'hABCD, '0);
    exp_q.push_back(mk(1'b0, 1'b1, '0, 32'hABCD));
    tick();
    drive(1'b1, OP_MFLO, '0, '0);
    tick();
    tick();
    n_checks++;
    if ({s_mfv, s_mfd} !== {1'b1, 32'hABCD}) begin
      n_fail++; $display("FAIL mflo_after_mtlo: got mfv=%0b data=%h, required 1 abcd", s_mfv, s_mfd);
    end
    drive(1'b0, 3'd0, '0, '0);
  endtask

  task automatic test_flush();
    aborts = 0;
    flush  = 1'b1;
    drive(1'b1, OP_MFHI, '0, '0);
    tick();
    n_checks++;
    if ({s_ready, s_mfv} !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle: got ready=%0b mfv=%0b, required 0 0", s_ready, s_mfv);
    end
    flush = 1'b0;
    drive(1'b1, OP_MULT, 32'd3, 32'd4);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    for (int i = 1; i <= 7; i++) begin
      flush       = (i == 4);
      unit_done   = (i == 5);
      unit_result = 64'd12;
      if (i == 5) drive(1'b1, OP_MFLO, '0, '0);
      if (i == 6) drive(1'b0, 3'd0, '0, '0);
      tick();
      if (i == 4) begin
        n_checks++;
        if ({s_abort, s_busy} !== 2'b11) begin
          n_fail++; $display("FAIL flush_busy_abort: got abort=%0b busy=%0b, required 1 1", s_abort, s_busy);
        end
      end
      if (i == 5) begin
        n_checks++;
        if ({s_ready, s_mfv} !== 2'b11) begin
          n_fail++; $display("FAIL flush_next_accept: got ready=%0b mfv=%0b, required 1 1", s_ready, s_mfv);
        end
      end
    end
    flush = 1'b0;
    unit_done = 1'b0;
    n_checks++;
    if (aborts !== 1) begin n_fail++; $display("FAIL flush_abort_count: got %0d, required 1", aborts); end
    drive(1'b1, OP_MTHI, 32'hDEAD, '0);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if ({s_hiwe, s_lowe} !== 2'b00) begin
      n_fail++; $display("FAIL flush_wb: got we=%b%b, required 00", s_hiwe, s_lowe);
    end
    drive(1'b1, OP_MFHI, '0, '0);
    tick();
    n_checks++;
    if (s_mfd !== 32'h1234) begin n_fail++; $display("FAIL flush_wb_hi_kept: got %h, required 1234", s_mfd); end
    drive(1'b0, 3'd0, '0, '0);
  endtask

  task automatic test_timeout();
    int abort_at = 0;
    aborts = 0;
    drive(1'b1, OP_MULTU, 32'd1, 32'd1);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (s_abort && abort_at == 0) abort_at = i;
    end
    n_checks++;
    if (abort_at !== 41 || aborts !== 1) begin
      n_fail++; $display("FAIL timeout_abort: got abort at cycle %0d count %0d, required cycle 41 count 1", abort_at, aborts);
    end
    drive(1'b1, OP_MFLO, '0, '0);
    tick();
    n_checks++;
    if ({s_err, s_busy, s_ready} !== 3'b101) begin
      n_fail++; $display("FAIL timeout_sticky: got err=%0b busy=%0b ready=%0b, required 1 0 1", s_err, s_busy, s_ready);
    end
    drive(1'b1, OP_MULTU, 32'd2, 32'd3);
    tick();
    drive(1'b0, 3'd0, '0, '0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (s_all !== '0 || aborts !== 1) begin
      n_fail++; $display("FAIL reset_midop: got outputs=%h aborts=%0d, required 0 and 1", s_all, aborts);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_done_at_timeout();
    aborts = 0;
    drive(1'b1, OP_MULTU, 32'd9, 32'd9);
    exp_q.push_back(mk(1'b1, 1'b1, 32'd0, 32'd81));
    tick();
    drive(1'b0, 3'd0, '0, '0);
    for (int i = 1; i <= 43; i++) begin
      unit_done   = (i == 41);
      unit_result = 64'd81;
      tick();
      if (i == 42) begin
        n_checks++;
        if ({s_hiwe, s_lowe} !== 2'b11) begin
          n_fail++; $display("FAIL done_wins_write: got we=%b%b, required 11", s_hiwe, s_lowe);
        end
      end
    end
    unit_done = 1'b0;
    n_checks++;
    if (aborts !== 0 || s_err !== 1'b0) begin
      n_fail++; $display("FAIL done_wins_no_abort: got aborts=%0d err=%0b, required 0 0", aborts, s_err);
    end
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    unit_done   = 1'b0;
    unit_result = '0;
    drive(1'b0, 3'd0, '0, '0);
    test_reset();
    test_multu();
    test_div_signed();
    test_div0();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_done_at_timeout();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
